// File: rtl/not_not_pkg.sv
// not_not_pkg: shared state, result codes and score limit for round_judge.
// round_limit() is used only when ROUND_JUDGE_SPEEDUP_EN is defined.
package not_not_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROUND,
        S_WAIT,
        S_JUDGE,
        S_SHOW,
        S_GAME_OVER
    } state_t;

    typedef enum logic [1:0] {
        RES_NONE    = 2'b00,
        RES_CORRECT = 2'b01,
        RES_WRONG   = 2'b10,
        RES_TIMEOUT = 2'b11
    } result_t;

    localparam logic [6:0] SCORE_MAX = 7'd99;

    // Round shortens by one second per ten points but never below two seconds.
    function automatic logic [3:0] round_limit(input logic [6:0] score, input int secs);
        int v;
        v = secs - int'(score / 7'd10);
        return (v < 2) ? 4'd2 : 4'(v);
    endfunction

endpackage

// File: rtl/button_edge.sv
// button_edge: 2-flop synchronizer for an active-low button plus press (1->0) detect.
module button_edge (
    input  logic clock,
    input  logic reset,
    input  logic btn_n,
    output logic press
);

    logic [2:0] sync;

    always_ff @(posedge clock or negedge reset)
        if (!reset) sync <= 3'b111;
        else        sync <= {sync[1:0], btn_n};

    // sync[1] is the synchronized level, sync[2] its previous value.
    assign press = sync[2] & ~sync[1];

endmodule

// File: rtl/round_judge.sv
// round_judge: timed answer-check game round controller with score, lives and result display.
// Define ROUND_JUDGE_SPEEDUP_EN to shorten rounds as the score grows.
module round_judge
    import not_not_pkg::*;
#(
    parameter int TICK_CYCLES = 50000000,
    parameter int ROUND_SECS  = 9,
    parameter int SHOW_CYCLES = 100000000,
    parameter int START_LIVES = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_n,
    input  logic       submit_n,
    input  logic [3:0] expected,
    input  logic [3:0] answer,
    output logic       next_round,
    output logic [3:0] time_left,
    output logic [6:0] score,
    output logic [1:0] lives,
    output logic [1:0] result,
    output logic       game_over
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int SW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_CYCLES - 1);
    localparam logic [SW-1:0] SHOW_MAX = SW'(SHOW_CYCLES - 1);
    localparam logic [1:0] LIVES0 = 2'(START_LIVES);

    state_t state, state_nx;
    logic [PW-1:0] presc, presc_nx;
    logic [SW-1:0] show_cnt, show_nx;
    logic [3:0] time_nx, limit;
    logic [6:0] score_nx;
    logic [1:0] lives_nx, lives_dec, result_nx;
    logic start_ev, submit_ev;

    button_edge u_start (
        .clock (clock),
        .reset (reset),
        .btn_n (start_n),
        .press (start_ev)
    );

    button_edge u_submit (
        .clock (clock),
        .reset (reset),
        .btn_n (submit_n),
        .press (submit_ev)
    );

`ifdef ROUND_JUDGE_SPEEDUP_EN
    assign limit = round_limit(score, ROUND_SECS);
`else
    assign limit = 4'(ROUND_SECS);
`endif

    assign lives_dec  = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
    assign next_round = state == S_ROUND;
    assign game_over  = state == S_GAME_OVER;

    always_comb begin
        state_nx  = state;
        presc_nx  = presc;
        show_nx   = '0;
        time_nx   = time_left;
        score_nx  = score;
        lives_nx  = lives;
        result_nx = result;
        case (state)
            S_IDLE, S_GAME_OVER:
                if (start_ev) begin
                    state_nx = S_ROUND;
                    score_nx = '0;
                    lives_nx = LIVES0;
                end
            S_ROUND: begin
                time_nx   = limit;
                presc_nx  = '0;
                result_nx = RES_NONE;
                state_nx  = S_WAIT;
            end
            // A submit wins over a simultaneous final wrap.
            S_WAIT:
                if (submit_ev) state_nx = S_JUDGE;
                else if (presc == TICK_MAX) begin
                    presc_nx = '0;
                    time_nx  = time_left - 4'd1;
                    if (time_left == 4'd1) begin
                        result_nx = RES_TIMEOUT;
                        lives_nx  = lives_dec;
                        state_nx  = S_SHOW;
                    end
                end else presc_nx = presc + 1'b1;
            S_JUDGE: begin
                if (answer == expected) begin
                    result_nx = RES_CORRECT;
                    score_nx  = (score == SCORE_MAX) ? score : score + 7'd1;
                end else begin
                    result_nx = RES_WRONG;
                    lives_nx  = lives_dec;
                end
                state_nx = S_SHOW;
            end
            S_SHOW:
                if (show_cnt == SHOW_MAX) state_nx = (lives == 2'd0) ? S_GAME_OVER : S_ROUND;
                else show_nx = show_cnt + 1'b1;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state     <= S_IDLE;
            presc     <= '0;
            show_cnt  <= '0;
            time_left <= '0;
            score     <= '0;
            lives     <= LIVES0;
            result    <= RES_NONE;
        end else begin
            state     <= state_nx;
            presc     <= presc_nx;
            show_cnt  <= show_nx;
            time_left <= time_nx;
            score     <= score_nx;
            lives     <= lives_nx;
            result    <= result_nx;
        end

endmodule

// File: doc/round_judge.md
ROUND_JUDGE -- requirements
Module: round_judge

Interface
REQ-001 Parameter TICK_CYCLES, 50000000, clock cycles per countdown second.
REQ-002 Parameter ROUND_SECS, 9, seconds allowed per round (1..15).
REQ-003 Parameter SHOW_CYCLES, 100000000, cycles the result is held before the next round.
REQ-004 Parameter START_LIVES, 3, lives at game start (1..3).
REQ-005 clock  in  1  single system clock, rising-edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start_n  in  1  raw active-low start button, asynchronous to clock.
REQ-008 submit_n  in  1  raw active-low submit button, asynchronous to clock.
REQ-009 expected  in  4  correct switch pattern from the rule/selector stage.
REQ-010 answer  in  4  player switch pattern.
REQ-011 next_round  out  1  one-cycle pulse that advances the upstream selector LFSRs.
REQ-012 time_left  out  4  seconds remaining in the current round.
REQ-013 score  out  7  correct answers, binary, 0..99.
REQ-014 lives  out  2  remaining lives.
REQ-015 result  out  2  00 none, 01 correct, 10 wrong, 11 timeout.
REQ-016 game_over  out  1  high while in GAME_OVER.

Function
REQ-017 start_n and submit_n SHALL each pass a 2-flop synchronizer; a press is a 1->0 transition of the synchronized value, yielding a one-cycle event.
REQ-018 FSM states SHALL be IDLE, ROUND, WAIT, JUDGE, SHOW, GAME_OVER.
REQ-019 IDLE: on start event -> ROUND with score=0 and lives=START_LIVES.
REQ-020 ROUND (one cycle): assert next_round, load time_left=round limit, clear prescaler and result -> WAIT.
REQ-021 WAIT: prescaler counts 0..TICK_CYCLES-1; at wrap time_left decrements by 1.
REQ-022 WAIT: submit event -> JUDGE; start events SHALL be ignored outside IDLE/GAME_OVER.
REQ-023 WAIT: wrap while time_left==1 -> time_left=0, result=11, lives-1, -> SHOW.
REQ-024 A submit event and the timeout wrap in the same cycle SHALL be treated as a submit.
REQ-025 JUDGE (one cycle): answer==expected -> result=01 and score+1, saturating at 99; else result=10 and lives-1; -> SHOW.
REQ-026 expected and answer SHALL be compared in JUDGE, never in ROUND, because upstream updates one cycle after next_round.
REQ-027 SHOW: hold result and time_left for SHOW_CYCLES cycles, then -> GAME_OVER if lives==0, else -> ROUND.
REQ-028 lives SHALL never decrement below 0.
REQ-029 GAME_OVER: outputs hold; start event -> ROUND with score=0 and lives=START_LIVES.
REQ-030 next_round SHALL be high for exactly one cycle per round and never in any other state.

Reset
REQ-031 reset low SHALL immediately force IDLE, next_round=0, time_left=0, score=0, lives=START_LIVES, result=00, game_over=0, clear prescaler, SHOW counter and synchronizers (synchronizers to 1).
REQ-032 Reset asserted mid-round SHALL discard the round without a next_round pulse.

Configuration
REQ-033 With macro ROUND_JUDGE_SPEEDUP_EN defined, round limit = max(ROUND_SECS - score/10, 2), score sampled in ROUND.
REQ-034 Without ROUND_JUDGE_SPEEDUP_EN, round limit = ROUND_SECS always.

Structure
REQ-035 Package not_not_pkg SHALL hold the FSM state enum, the result codes, and the score limit 99.
REQ-036 Sub-module button_edge (synchronizer plus falling-edge detect) SHALL be instantiated twice.

Verification
REQ-038 Reset, start press, expected=4'b0010, answer=4'b0010, submit in second 3 -> one next_round pulse, result=01, score=1, lives=3, new round after SHOW_CYCLES.
REQ-039 expected=4'b1101, answer=4'b0010, submit -> result=10, lives 3->2, score unchanged.
REQ-040 No submit, TICK_CYCLES=4, ROUND_SECS=3 -> time_left 3,2,1,0 at 4-cycle steps, result=11, lives-1; at lives=0 game_over=1 after SHOW.
REQ-041 Submit event on the same cycle as the final wrap with a correct answer -> result=01, no life lost.
REQ-042 score preloaded to 99 via 99 correct rounds, one more correct -> score stays 99; with ROUND_JUDGE_SPEEDUP_EN, round limit=2 once score>=70 (ROUND_SECS=9).
REQ-043 reset pulsed low during WAIT -> all outputs at reset values that cycle, no next_round, start required to resume.
